// File: rtl/io_stream_array_buffer_pkg.sv
// -----------------------------------------------------------------------------
// io_stream_array_buffer_pkg
// Shared primitives for the stream/array buffer: the FSM state encoding and
// the state register width. Constants only; no types are introduced here.
// -----------------------------------------------------------------------------
package io_stream_array_buffer_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_FILL  = 3'd1;
  localparam logic [STATE_W-1:0] ST_READ  = 3'd2;
  localparam logic [STATE_W-1:0] ST_LATCH = 3'd3;
  localparam logic [STATE_W-1:0] ST_EMIT  = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/io_stream_array_buffer_if.sv
// -----------------------------------------------------------------------------
// io_stream_array_buffer_if
// Request/response bus between the buffer and its external word array.
//   arr_addr  word address            (buffer -> array)
//   arr_we    1 = write, 0 = read     (buffer -> array)
//   arr_di    write data              (buffer -> array)
//   arr_valid request present         (buffer -> array)
//   arr_ready array accepts request   (array  -> buffer)
//   arr_do    read data, valid the cycle after an accepted read (array -> buffer)
// Modports: master = buffer side, slave = array side.
// -----------------------------------------------------------------------------
interface io_stream_array_buffer_if #(
  parameter int INT_N  = 8,
  parameter int ADDR_N = 8
);

  logic [ADDR_N-1:0] arr_addr;
  logic              arr_we;
  logic [INT_N-1:0]  arr_di;
  logic              arr_valid;
  logic              arr_ready;
  logic [INT_N-1:0]  arr_do;

  modport master (
    output arr_addr,
    output arr_we,
    output arr_di,
    output arr_valid,
    input  arr_ready,
    input  arr_do
  );

  modport slave (
    input  arr_addr,
    input  arr_we,
    input  arr_di,
    input  arr_valid,
    output arr_ready,
    output arr_do
  );

endinterface

// File: rtl/io_stream_array_buffer.sv
// -----------------------------------------------------------------------------
// io_stream_array_buffer
// Buffers a stream of len words into an external array, then replays the
// array contents in order on the output stream.
//
// Ports
//   clk, nrst              clock, asynchronous active-low reset
//   in_valid / in_ready    start handshake; len sampled on acceptance
//   out_valid / out_ready  completion handshake
//   sIn, sIn_valid/ready   input stream (accepted only while filling)
//   sOut, sOut_valid/ready output stream (one word per READ/LATCH/EMIT pass)
//   arr                    array bus (master side)
//   sum                    running checksum of filled words (optional)
//
// Build option: define IO_STREAM_CHECKSUM_EN to add the sum output and its
// accumulator (mod 2^INT_N, cleared on start, updated on every fill beat).
// -----------------------------------------------------------------------------
module io_stream_array_buffer
  import io_stream_array_buffer_pkg::*;
#(
  parameter int INT_N  = 8,
  parameter int ADDR_N = 8
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic [ADDR_N-1:0]         len,
  input  logic [INT_N-1:0]          sIn,
  input  logic                      sIn_valid,
  output logic                      sIn_ready,
  output logic [INT_N-1:0]          sOut,
  output logic                      sOut_valid,
  input  logic                      sOut_ready,
`ifdef IO_STREAM_CHECKSUM_EN
  output logic [INT_N-1:0]          sum,
`endif
  io_stream_array_buffer_if.master  arr
);

  logic [STATE_W-1:0] state;
  logic [ADDR_N-1:0]  index;
  logic [ADDR_N-1:0]  len_q;
  logic [INT_N-1:0]   out_q;

  logic st_idle, st_fill, st_read, st_latch, st_emit, st_done;
  logic fill_beat;
  logic at_last;

  assign st_idle  = (state == ST_IDLE);
  assign st_fill  = (state == ST_FILL);
  assign st_read  = (state == ST_READ);
  assign st_latch = (state == ST_LATCH);
  assign st_emit  = (state == ST_EMIT);
  assign st_done  = (state == ST_DONE);

  // A fill beat needs both the producer and the array in the same cycle; the
  // array write is issued in that very cycle, so nothing is buffered locally.
  assign fill_beat = st_fill && sIn_valid && arr.arr_ready;

  // len_q is never 0 outside IDLE/DONE, so len_q-1 cannot underflow where used.
  assign at_last = (index == (len_q - ADDR_N'(1)));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
      index <= '0;
      len_q <= '0;
      out_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            len_q <= len;
            index <= '0;
            state <= (len != '0) ? ST_FILL : ST_DONE;
          end
        end
        ST_FILL: begin
          if (fill_beat) begin
            if (at_last) begin
              index <= '0;
              state <= ST_READ;
            end else begin
              index <= index + ADDR_N'(1);
            end
          end
        end
        ST_READ: begin
          if (arr.arr_ready) state <= ST_LATCH;
        end
        ST_LATCH: begin
          // Read data arrives the cycle after the accepted read request.
          out_q <= arr.arr_do;
          state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (sOut_ready) begin
            if (at_last) begin
              state <= ST_DONE;
            end else begin
              index <= index + ADDR_N'(1);
              state <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IO_STREAM_CHECKSUM_EN
  logic [INT_N-1:0] sum_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sum_q <= '0;
    end else if (st_idle && in_valid) begin
      sum_q <= '0;
    end else if (fill_beat) begin
      sum_q <= sum_q + sIn;
    end
  end

  assign sum = sum_q;
`endif

  assign in_ready   = st_idle;
  assign out_valid  = st_done;
  assign sIn_ready  = st_fill && arr.arr_ready;
  assign sOut_valid = st_emit;
  assign sOut       = out_q;

  // Array requests are gated to FILL/READ so the bus idles at zero elsewhere;
  // during FILL a request is raised only when there is a word to write.
  assign arr.arr_valid = (st_fill && sIn_valid) || st_read;
  assign arr.arr_we    = st_fill;
  assign arr.arr_addr  = (st_fill || st_read) ? index : '0;
  assign arr.arr_di    = st_fill ? sIn : '0;

  // LATCH only moves data; no bus or stream activity in that state.
  logic unused_latch;
  assign unused_latch = st_latch;

endmodule

// File: tb/tb_io_stream_array_buffer.sv
`timescale 1ns/1ps
module tb_io_stream_array_buffer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] len;
  logic [7:0] sIn, sOut;
  logic       sIn_valid, sIn_ready, sOut_valid, sOut_ready;
`ifdef IO_STREAM_CHECKSUM_EN
  logic [7:0] sum;
`endif

  io_stream_array_buffer_if #(.INT_N(8), .ADDR_N(8)) arr_bus ();

  io_stream_array_buffer #(.INT_N(8), .ADDR_N(8)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .len        (len),
    .sIn        (sIn),
    .sIn_valid  (sIn_valid),
    .sIn_ready  (sIn_ready),
    .sOut       (sOut),
    .sOut_valid (sOut_valid),
    .sOut_ready (sOut_ready),
`ifdef IO_STREAM_CHECKSUM_EN
    .sum        (sum),
`endif
    .arr        (arr_bus)
  );

  // Behavioural word array: write on accepted write, registered read data.
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (arr_bus.arr_valid && arr_bus.arr_ready) begin
      if (arr_bus.arr_we) mem[arr_bus.arr_addr] <= arr_bus.arr_di;
      else                arr_bus.arr_do <= mem[arr_bus.arr_addr];
    end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] src [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_sin_ready"}, sIn_ready, 0);
    chk({tag, "_sout_valid"}, sOut_valid, 0);
    chk({tag, "_sout"},      sOut, 0);
    chk({tag, "_arr_valid"}, arr_bus.arr_valid, 0);
    chk({tag, "_arr_we"},    arr_bus.arr_we, 0);
    chk({tag, "_arr_addr"},  arr_bus.arr_addr, 0);
    chk({tag, "_arr_di"},    arr_bus.arr_di, 0);
`ifdef IO_STREAM_CHECKSUM_EN
    chk({tag, "_sum"},       sum, 0);
`endif
  endtask

  task automatic fill_ramp(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(8'(i));
  endtask

  task automatic fill_rand(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(8'($urandom));
  endtask

  // amode: 0 arr_ready=1, 1 random, 2 toggling
  // omode: 0 sOut_ready=1, 1 random, 2 stall 5 cycles per word
  // imode: 0 sIn_valid=1, 1 random
  // hold : keep in_valid high throughout, out_ready=1
  // abort_word: >=0 pulses reset during READ of that word
  task automatic run_xfer(input int n, input int amode, input int omode,
                          input int imode, input bit hold, input int abort_word);
    int sent = 0, k = 0, cyc = 0, last_fill = -1, last_hs = -1, vcnt = 0;
    int exp_sum = 0;
    bit prev_hold = 0, tog = 0, fin = 0, aborted = 0;
    logic [7:0] prev_sout = 0;
    foreach (src[i]) exp_sum = (exp_sum + int'(src[i])) % 256;

    @(negedge clk);
    in_valid = 1; len = 8'(n); out_ready = 0; sIn_valid = 0; sOut_ready = 0;
    arr_bus.arr_ready = 1;
    #1 chk("start_ready", in_ready, 1);

    while (!fin && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      in_valid = hold;
      case (amode)
        0: arr_bus.arr_ready = 1'b1;
        1: arr_bus.arr_ready = 1'($urandom_range(0, 1));
        default: begin tog = ~tog; arr_bus.arr_ready = tog; end
      endcase
      sIn_valid  = (imode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      sIn        = (sent < n) ? src[sent] : 8'($urandom);
      sOut_ready = (omode == 0) ? 1'b1 : (omode == 1) ? 1'($urandom_range(0, 1)) : (vcnt >= 5);
      out_ready  = hold ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      chk("in_ready_busy", in_ready, 0);
      if (n == 0 && cyc == 1) chk("len0_done", out_valid, 1);
      if (sent == n) chk("sin_ready_closed", sIn_ready, 0);
      if (sent == n && k == n) chk("arr_valid_quiet", arr_bus.arr_valid, 0);
      if (prev_hold) begin
        chk("sout_hold_valid", sOut_valid, 1);
        chk("sout_hold_data", sOut, prev_sout);
      end
      if (sIn_valid && sIn_ready) begin
        chk("wr_valid", arr_bus.arr_valid, 1);
        chk("wr_we", arr_bus.arr_we, 1);
        chk("wr_addr", arr_bus.arr_addr, sent);
        chk("wr_data", arr_bus.arr_di, sIn);
        sent++;
        last_fill = cyc;
      end
      if (arr_bus.arr_valid && !arr_bus.arr_we) begin
        chk("rd_addr", arr_bus.arr_addr, k);
        chk("rd_after_fill", sent, n);
        if (abort_word >= 0 && k == abort_word) begin
          nrst = 0;
          #1 check_reset_outputs("rst_mid");
          in_valid = 0;
          repeat (2) begin
            @(negedge clk);
            #1 chk("rst_hold_arr_valid", arr_bus.arr_valid, 0);
          end
          @(negedge clk);
          nrst = 1;
          repeat (3) begin
            #1 chk("rst_after_arr_valid", arr_bus.arr_valid, 0);
            chk("rst_after_in_ready", in_ready, 1);
            @(negedge clk);
          end
          aborted = 1;
          fin = 1;
        end
      end
      if (!aborted) begin
        if (sOut_valid) begin
          chk("sout_after_fill", sent, n);
          if (sOut_ready) begin
            if (k < n) chk("sout_data", sOut, src[k]);
            else       chk("sout_overrun", k, n - 1);
            if (amode == 0 && omode == 0)
              chk("sout_latency", cyc - ((k == 0) ? last_fill : last_hs), 3);
            last_hs = cyc; k++; vcnt = 0; prev_hold = 0;
          end else begin
            vcnt++; prev_hold = 1; prev_sout = sOut;
          end
        end else begin
          prev_hold = 0;
        end
        if (out_valid) begin
          chk("done_count", k, n);
          chk("done_fill", sent, n);
`ifdef IO_STREAM_CHECKSUM_EN
          chk("sum", sum, exp_sum);
`endif
          if (out_ready) fin = 1;
        end
      end
    end
    if (!fin) chk("xfer_timeout", 0, 1);

    if (!aborted) begin
      @(negedge clk);
      if (hold) begin
        len = 0;
        in_valid = 1;
        #1 chk("restart_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 0; out_ready = 1;
        #1 chk("restart_done", out_valid, 1);
        @(negedge clk);
      end else begin
        in_valid = 0;
      end
      #1 chk("idle_after_done", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
    end
    in_valid = 0;
  endtask

  initial begin
    nrst = 0; in_valid = 0; out_ready = 0; len = 0; sIn = 0;
    sIn_valid = 0; sOut_ready = 0; arr_bus.arr_ready = 0;
    #2 check_reset_outputs("rst");
    repeat (3) @(negedge clk);
    nrst = 1;
    #1 check_reset_outputs("post_rst");

    fill_ramp(16); run_xfer(16, 0, 0, 0, 0, -1);
    src.delete();  run_xfer(0, 0, 0, 0, 0, -1);
    fill_ramp(4);  run_xfer(4, 2, 2, 0, 0, -1);
    fill_ramp(8);  run_xfer(8, 0, 0, 0, 0, 2);
    src.delete(); src.push_back(8'd255); src.push_back(8'd2);
    run_xfer(2, 0, 0, 0, 0, -1);
    fill_ramp(3);  run_xfer(3, 1, 1, 1, 1, -1);
    fill_rand(255); run_xfer(255, 0, 0, 0, 0, -1);
    repeat (12) begin
      int n;
      n = $urandom_range(0, 20);
      fill_rand(n);
      run_xfer(n, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1), 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
